// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a multi-cycle MIPS datapath with one shared memory
//   port, one ALU, IR/PC registers and a register file. Each state drives the
//   mux selects and write enables for that step of the instruction. The FSM
//   stalls in FETCH, MEMRD and MEMWR until the memory reports mem_ready.
//
//   Optional build macro: ILLEGAL_TRAP_EN
//     defined   : an unknown opcode parks the FSM in TRAP until reset, and the
//                 illegal_op output is present.
//     undefined : an unknown opcode completes as a two-cycle NOP.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; forces state FETCH, outputs 0
//   Opcode     in   IR[31:26], looked at only in DECODE and MEMADR
//   mem_ready  in   memory finishes the current access this cycle
//   mem_req    out  memory access requested
//   IorD       out  memory address: 0=PC, 1=ALUOut
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register load
//   PCWrite    out  unconditional PC load
//   Branch     out  conditional PC load (ANDed with zero in the datapath)
//   PCSrc      out  00=ALU result, 01=ALUOut, 10=jump target
//   ALUSrcA    out  0=PC, 1=rs
//   ALUSrcB    out  00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   ALUOp      out  00=add, 01=sub, 10=funct, 11=immediate op
//   RegDst     out  0=rt, 1=rd
//   MemtoReg   out  0=ALUOut, 1=memory data register
//   RegWrite   out  register file write
//   instr_done out  pulse in the last cycle of every instruction
//   state      out  current state encoding (debug)
//   illegal_op out  high while in TRAP (ILLEGAL_TRAP_EN builds only)

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_t r_state;

  // Opcode belongs to the supported set; anything else is a NOP or a trap.
  logic w_known;
  assign w_known = Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                                  OP_ADDI, OP_ORI};

  // ---------------------------------------------------------------------
  // State register and transitions
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW:     r_state <= S_MEMADR;
            OP_RTYPE:         r_state <= S_EXECUTE;
            OP_BEQ:           r_state <= S_BRANCH;
            OP_J:             r_state <= S_JUMP;
            OP_ADDI, OP_ORI:  r_state <= S_IMMEX;
`ifdef ILLEGAL_TRAP_EN
            default:          r_state <= S_TRAP;
`else
            default:          r_state <= S_FETCH;
`endif
          endcase
        end
        // Opcode is re-examined here to pick the read or write path. If IR
        // somehow no longer holds a load/store, abandon the instruction
        // rather than touch memory.
        S_MEMADR: begin
          if (Opcode == OP_LW)      r_state <= S_MEMRD;
          else if (Opcode == OP_SW) r_state <= S_MEMWR;
          else                      r_state <= S_FETCH;
        end
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
        S_EXECUTE: r_state <= S_ALUWB;
        S_ALUWB:   r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_JUMP:    r_state <= S_FETCH;
        S_IMMEX:   r_state <= S_IMMWB;
        S_IMMWB:   r_state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:    r_state <= S_TRAP;   // only reset leaves TRAP
`endif
        // Unused encodings (and TRAP when the trap feature is absent)
        // recover to FETCH.
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Per-state output decode (Moore, plus mem_ready in the stall states)
  // ---------------------------------------------------------------------
  logic       w_mem_req, w_iord, w_memwrite, w_irwrite, w_pcwrite, w_branch;
  logic [1:0] w_pcsrc, w_alusrcb, w_aluop;
  logic       w_alusrca, w_regdst, w_memtoreg, w_regwrite, w_instr_done;

  always_comb begin
    w_mem_req    = 1'b0;
    w_iord       = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_pcsrc      = 2'b00;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_aluop      = 2'b00;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle, but IR and PC only load on the
        // cycle the memory actually returns the instruction.
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        // Branch target PC + (imm<<2) is precomputed into ALUOut.
        w_alusrcb = 2'b11;
`ifndef ILLEGAL_TRAP_EN
        w_instr_done = ~w_known;
`endif
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe held for the whole stall; memory commits on ready.
        w_mem_req    = 1'b1;
        w_iord       = 1'b1;
        w_memwrite   = 1'b1;
        w_instr_done = mem_ready;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca    = 1'b1;
        w_aluop      = 2'b01;
        w_branch     = 1'b1;
        w_pcsrc      = 2'b01;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite    = 1'b1;
        w_pcsrc      = 2'b10;
        w_instr_done = 1'b1;
      end
      S_IMMEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
      end
      S_IMMWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;  // TRAP and unused encodings: everything stays 0
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // In trap builds the unknown-opcode flag only steers the DECODE transition.
  logic w_unused_known;
  assign w_unused_known = w_known;
`endif

  // Reset gates every output combinationally so an in-flight access or write
  // is dropped the instant reset rises, not at the next clock edge.
  assign mem_req    = w_mem_req    & ~reset;
  assign IorD       = w_iord       & ~reset;
  assign MemWrite   = w_memwrite   & ~reset;
  assign IRWrite    = w_irwrite    & ~reset;
  assign PCWrite    = w_pcwrite    & ~reset;
  assign Branch     = w_branch     & ~reset;
  assign PCSrc      = reset ? 2'b00 : w_pcsrc;
  assign ALUSrcA    = w_alusrca    & ~reset;
  assign ALUSrcB    = reset ? 2'b00 : w_alusrcb;
  assign ALUOp      = reset ? 2'b00 : w_aluop;
  assign RegDst     = w_regdst     & ~reset;
  assign MemtoReg   = w_memtoreg   & ~reset;
  assign RegWrite   = w_regwrite   & ~reset;
  assign instr_done = w_instr_done & ~reset;
  assign state      = reset ? 4'd0 : r_state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == S_TRAP) & ~reset;
`endif

endmodule
